// File: rtl/program_counter.sv
// Instruction-address register: loads an absolute target or adds a sign-extended relative offset.
// Optional macro PC_OVERFLOW_FLAG_EN adds a registered Overflow flag for wrapping offset adds.
module program_counter #(
  parameter int                OFFSET_WIDTH = 9,
  parameter int                WIDTH        = 16,
  parameter logic [WIDTH-1:0]  RESET_VALUE  = '0
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic signed [WIDTH-1:0]         LoadValue,
  input  logic                            LoadEnable,
  input  logic signed [OFFSET_WIDTH-1:0]  Offset,
  input  logic                            OffsetEnable,
  output logic signed [WIDTH-1:0]         CounterValue
`ifdef PC_OVERFLOW_FLAG_EN
  ,
  output logic                            Overflow
`endif
);

  logic                     rst_sync_p0;
  logic                     rst_sync_p1;
  logic signed [WIDTH-1:0]  pc_p0;
  logic signed [WIDTH-1:0]  pc_nxt;

  function automatic logic signed [WIDTH-1:0] sext(input logic signed [OFFSET_WIDTH-1:0] v);
    return {{(WIDTH-OFFSET_WIDTH){v[OFFSET_WIDTH-1]}}, v};
  endfunction

`ifdef PC_OVERFLOW_FLAG_EN
  logic ovf_p0;
  logic ovf_nxt;

  // Returns {wrap, sum}; a negative offset wraps when the unsigned add produces no carry (borrow).
  function automatic logic [WIDTH:0] add_wrap(input logic signed [WIDTH-1:0] pc,
                                              input logic signed [OFFSET_WIDTH-1:0] off);
    logic [WIDTH:0] sum_ext;
    sum_ext = {1'b0, pc} + {1'b0, sext(off)};
    return {(off[OFFSET_WIDTH-1] ? ~sum_ext[WIDTH] : sum_ext[WIDTH]), sum_ext[WIDTH-1:0]};
  endfunction
`else
  function automatic logic signed [WIDTH-1:0] add_mod(input logic signed [WIDTH-1:0] pc,
                                                      input logic signed [OFFSET_WIDTH-1:0] off);
    return pc + sext(off);
  endfunction
`endif

  // Reset stage: assert immediately, release after two Clock edges
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rst_sync_p0 <= 1'b0;
      rst_sync_p1 <= 1'b0;
    end else begin
      rst_sync_p0 <= 1'b1;
      rst_sync_p1 <= rst_sync_p0;
    end
  end

  always_comb begin
    pc_nxt = pc_p0;
`ifdef PC_OVERFLOW_FLAG_EN
    ovf_nxt = 1'b0;
`endif
    if (LoadEnable) begin
      pc_nxt = LoadValue;
    end else if (OffsetEnable) begin
`ifdef PC_OVERFLOW_FLAG_EN
      {ovf_nxt, pc_nxt} = add_wrap(pc_p0, Offset);
`else
      pc_nxt = add_mod(pc_p0, Offset);
`endif
    end
  end

  // Counter stage
  always_ff @(posedge Clock or negedge rst_sync_p1) begin
    if (!rst_sync_p1) begin
      pc_p0 <= RESET_VALUE;
    end else begin
      pc_p0 <= pc_nxt;
    end
  end

  assign CounterValue = pc_p0;

`ifdef PC_OVERFLOW_FLAG_EN
  always_ff @(posedge Clock or negedge rst_sync_p1) begin
    if (!rst_sync_p1) begin
      ovf_p0 <= 1'b0;
    end else begin
      ovf_p0 <= ovf_nxt;
    end
  end

  assign Overflow = ovf_p0;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed spec scenarios, then random traffic against an arithmetic model.
module tb_program_counter;

  localparam int W  = 16;
  localparam int OW = 9;
  localparam logic [W-1:0] RV = 16'h0000;

  logic                  Clock = 1'b0;
  logic                  Reset;
  logic signed [W-1:0]   LoadValue;
  logic                  LoadEnable;
  logic signed [OW-1:0]  Offset;
  logic                  OffsetEnable;
  logic signed [W-1:0]   CounterValue;
`ifdef PC_OVERFLOW_FLAG_EN
  logic                  Overflow;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [W-1:0] m_pc;
  logic         m_ovf;
  int           rel;   // consecutive edges seen with Reset high

  program_counter #(.WIDTH(W), .OFFSET_WIDTH(OW), .RESET_VALUE(RV)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .LoadValue   (LoadValue),
    .LoadEnable  (LoadEnable),
    .Offset      (Offset),
    .OffsetEnable(OffsetEnable),
    .CounterValue(CounterValue)
`ifdef PC_OVERFLOW_FLAG_EN
    ,
    .Overflow    (Overflow)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic check_pc(input string tag, input logic [W-1:0] exp);
    checks++;
    assert (CounterValue === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, CounterValue, exp);
    end
  endtask

  task automatic check_ovf(input string tag, input logic exp);
`ifdef PC_OVERFLOW_FLAG_EN
    checks++;
    assert (Overflow === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, Overflow, exp);
    end
`else
    if (exp === 1'bx) $display("unused");
`endif
  endtask

  // One clock edge: update the model from the sampled inputs, then compare just after the edge.
  task automatic tick(input string tag);
    int s;
    @(posedge Clock);
    if (!Reset) begin
      m_pc  = RV;
      m_ovf = 1'b0;
      rel   = 0;
    end else begin
      m_ovf = 1'b0;
      if (rel >= 2) begin
        if (LoadEnable) begin
          m_pc = LoadValue;
        end else if (OffsetEnable) begin
          s     = int'(m_pc) + int'(Offset);
          m_ovf = (s < 0) || (s > 65535);
          m_pc  = 16'(s);
        end
      end
      rel++;
    end
    #1;
    check_pc(tag, m_pc);
    check_ovf({tag, "_ovf"}, m_ovf);
  endtask

  task automatic drive(input logic le, input logic [W-1:0] lv, input logic oe, input logic [OW-1:0] off);
    LoadEnable   = le;
    LoadValue    = lv;
    OffsetEnable = oe;
    Offset       = off;
  endtask

  initial begin
    Reset = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 9'h0);
    m_pc  = RV;
    m_ovf = 1'b0;
    rel   = 0;

    // Asynchronous assertion before any clock edge
    #2 Reset = 1'b0;
    #1 check_pc("rst_async", 16'h0000);
    tick("rst_low");
    Reset = 1'b1;
    tick("rst_rel1");
    check_pc("rst_rel1_const", 16'h0000);
    tick("rst_rel2");

    drive(1'b1, 16'h1234, 1'b0, 9'h0);
    tick("load");
    check_pc("load_const", 16'h1234);
    drive(1'b0, 16'h0, 1'b0, 9'h0);
    tick("hold");
    check_pc("hold_const", 16'h1234);

    drive(1'b0, 16'h0, 1'b1, 9'h01F);
    tick("off_1f");
    check_pc("off_1f_const", 16'h1253);
    drive(1'b0, 16'h0, 1'b1, 9'h0FF);
    tick("off_0ff");
    check_pc("off_0ff_const", 16'h1352);
    drive(1'b0, 16'h0, 1'b1, 9'h1FF);
    tick("off_m1");
    check_pc("off_m1_const", 16'h1351);

    drive(1'b1, 16'hFFFF, 1'b0, 9'h0);
    tick("load_ffff");
    drive(1'b0, 16'h0, 1'b1, 9'h001);
    tick("wrap_up");
    check_pc("wrap_up_const", 16'h0000);
    check_ovf("wrap_up_flag", 1'b1);
    drive(1'b0, 16'h0, 1'b1, 9'h1FF);
    tick("wrap_down");
    check_pc("wrap_down_const", 16'hFFFF);
    check_ovf("wrap_down_flag", 1'b1);
    drive(1'b0, 16'h0, 1'b0, 9'h0);
    tick("ovf_clear");
    check_ovf("ovf_clear_flag", 1'b0);

    // Reset dominates active enables; then load beats offset once released
    drive(1'b1, 16'h5678, 1'b1, 9'h00A);
    Reset = 1'b0;
    #1 check_pc("rst_en_async", 16'h0000);
    tick("rst_en");
    Reset = 1'b1;
    tick("rel_en1");
    tick("rel_en2");
    tick("rel_en3");
    check_pc("load_beats_off", 16'h5678);

    // Reset asserted between edges takes effect without an edge
    drive(1'b0, 16'h0, 1'b0, 9'h0);
    #2 Reset = 1'b0;
    #1 check_pc("rst_mid", RV);
    m_pc  = RV;
    m_ovf = 1'b0;
    rel   = 0;
    tick("rst_mid_edge");
    Reset = 1'b1;

    // Random traffic, biased towards the wrap boundaries
    for (int i = 0; i < 400; i++) begin
      Reset        = ($urandom_range(0, 49) != 0);
      LoadEnable   = ($urandom_range(0, 3) == 0);
      OffsetEnable = ($urandom_range(0, 1) == 1);
      LoadValue    = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'(16'hFF00 + 16'($urandom_range(0, 511)));
      Offset       = 9'($urandom);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
